// File: rtl/aes_mode_pkg.sv
// rtl/aes_mode_pkg.sv - shared types and constants for the AES block-mode controller
//
// Purpose: block width, din_type codes, chaining mode codes and the
// controller FSM state type, imported by every file of the controller.
package aes_mode_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    DT_KEY   = 2'b00,
    DT_IV    = 2'b01,
    DT_PLAIN = 2'b10,
    DT_RSVD  = 2'b11
  } din_type_e;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/aes_mode_ctrl_if.sv
// rtl/aes_mode_ctrl_if.sv - word input and ciphertext beat handshakes of the AES mode controller
//
// Purpose: bundles the din (word in) and dout (beat out) valid/ready streams.
// Signals:
//   din[DIN_W], din_type[2], din_valid, din_ready   - input words, MSB word first
//   dout[DOUT_W], dout_valid, dout_ready, dout_last - ciphertext beats, MSB beat first
// Modports: master = host side, slave = controller side.
interface aes_mode_ctrl_if #(
  parameter int DIN_W  = 8,
  parameter int DOUT_W = 8
) ();

  logic [DIN_W-1:0]  din;
  logic [1:0]        din_type;
  logic              din_valid;
  logic              din_ready;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output din, din_type, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );

  modport slave (
    input  din, din_type, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );

endinterface

// File: rtl/aes_out_fifo_ser.sv
// rtl/aes_out_fifo_ser.sv - ciphertext block FIFO with DOUT_W-bit beat serializer
//
// Purpose: holds up to OUT_DEPTH 128-bit blocks and emits the head block as
// 128/DOUT_W beats, MSB beat first; the block is popped on its last beat.
// Ports:
//   clk, rst_                - clock, asynchronous active-high reset
//   push, push_data[128]     - write one block (never issued when full)
//   full, level              - occupancy in blocks
//   dout, dout_valid, dout_ready, dout_last - beat handshake
module aes_out_fifo_ser
  import aes_mode_pkg::*;
#(
  parameter int DOUT_W    = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           push,
  input  logic [BLOCK_W-1:0]             push_data,
  output logic                           full,
  output logic [$clog2(OUT_DEPTH+1)-1:0] level,
  output logic [DOUT_W-1:0]              dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           dout_last
);

  localparam int BEATS  = BLOCK_W / DOUT_W;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LVL_W  = $clog2(OUT_DEPTH + 1);

  logic [BLOCK_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [BEAT_W-1:0]  beat;
  logic [BLOCK_W-1:0] head_shifted;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dout_valid   = (level != '0);
  assign dout_last    = dout_valid && (beat == BEAT_W'(BEATS - 1));
  assign full         = (level == LVL_W'(OUT_DEPTH));
  // Beat 0 is the most significant slice of the head block.
  assign head_shifted = mem[rd_ptr] >> (DOUT_W * (BEATS - 1 - int'(beat)));
  // Gated so an empty FIFO never shows a stale block.
  assign dout         = dout_valid ? head_shifted[DOUT_W-1:0] : '0;
  assign pop          = dout_valid && dout_ready && dout_last;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat   <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (dout_valid && dout_ready) begin
        if (dout_last) begin
          beat   <= '0;
          rd_ptr <= ptr_inc(rd_ptr);
        end else begin
          beat <= beat + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - AES block-mode controller: word packing, ECB/CBC chaining, core sequencing
//
// Purpose: packs DIN_W-bit words into key/IV/plaintext blocks, chains
// plaintext with the IV/previous ciphertext in CBC, drives the core
// start/done/read handshake and queues ciphertext for beat output.
// Ports:
//   clk, rst_                 - clock, asynchronous active-high reset
//   mode                      - 0 ECB, 1 CBC; captured when a plaintext block completes
//   io (slave)                - din/dout streams
//   core_key, core_block      - key and chained block to the core
//   core_start, core_read     - one-cycle pulses to the core
//   core_done, core_cipher    - core result (level) and ciphertext
//   fifo_level, busy, err     - status; err is a one-cycle pulse
module aes_mode_ctrl
  import aes_mode_pkg::*;
#(
  parameter int DIN_W     = 8,
  parameter int DOUT_W    = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           mode,
  aes_mode_ctrl_if.slave                 io,
  output logic [BLOCK_W-1:0]             core_key,
  output logic [BLOCK_W-1:0]             core_block,
  output logic                           core_start,
  input  logic                           core_done,
  input  logic [BLOCK_W-1:0]             core_cipher,
  output logic                           core_read,
  output logic [$clog2(OUT_DEPTH+1)-1:0] fifo_level,
  output logic                           busy,
  output logic                           err
);

  localparam int WORDS = BLOCK_W / DIN_W;
  localparam int CNT_W = $clog2(WORDS) + 1;

  if ((DIN_W < 8) || (DOUT_W < 8) || (DIN_W > BLOCK_W) || (DOUT_W > BLOCK_W) ||
      ((BLOCK_W % DIN_W) != 0) || ((BLOCK_W % DOUT_W) != 0) || (OUT_DEPTH < 1)) begin : g_bad_params
    $error("aes_mode_ctrl: DIN_W/DOUT_W must divide 128 and OUT_DEPTH must be >= 1");
  end

  state_e             state;
  din_type_e          blk_type;
  din_type_e          cur_type;
  logic [BLOCK_W-1:0] acc;
  logic [BLOCK_W-1:0] acc_shift;
  logic [BLOCK_W-1:0] chain;
  logic [CNT_W-1:0]   cnt;
  logic               mode_r;
  logic               fifo_full;
  logic               accept;
  logic               last_word;
  logic               push;

  assign cur_type     = din_type_e'(io.din_type);
  // Held low during reset so every output reads 0 while rst_ is high.
  assign io.din_ready = !rst_ && (state == ST_ACCUM) && !fifo_full;
  assign accept       = io.din_valid && io.din_ready;
  assign acc_shift    = (acc << DIN_W) | BLOCK_W'(io.din);
  assign last_word    = (cnt == CNT_W'(WORDS - 1));
  assign push         = (state == ST_CAPTURE);
  assign busy         = (state != ST_ACCUM);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state      <= ST_ACCUM;
      blk_type   <= DT_KEY;
      acc        <= '0;
      chain      <= '0;
      cnt        <= '0;
      mode_r     <= MODE_ECB;
      core_key   <= '0;
      core_block <= '0;
      core_start <= 1'b0;
      core_read  <= 1'b0;
      err        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_read  <= 1'b0;
      err        <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (cur_type == DT_RSVD) begin
              err <= 1'b1;
            end else if ((cnt != '0) && (cur_type != blk_type)) begin
              // Partial block is abandoned; this word opens a fresh block.
              err      <= 1'b1;
              acc      <= BLOCK_W'(io.din);
              cnt      <= CNT_W'(1);
              blk_type <= cur_type;
            end else if (last_word) begin
              cnt <= '0;
              acc <= acc_shift;
              case (cur_type)
                DT_KEY: core_key <= acc_shift;
                DT_IV:  chain    <= acc_shift;
                default: begin
                  // Block and start are registered together so core_start
                  // lands in the cycle right after the last word.
                  core_block <= (mode == MODE_CBC) ? (acc_shift ^ chain) : acc_shift;
                  mode_r     <= mode;
                  core_start <= 1'b1;
                  state      <= ST_START;
                end
              endcase
            end else begin
              acc      <= acc_shift;
              cnt      <= cnt + 1'b1;
              blk_type <= cur_type;
            end
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            core_read <= 1'b1;
            state     <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (mode_r == MODE_CBC) chain <= core_cipher;
          state <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  aes_out_fifo_ser #(
    .DOUT_W    (DOUT_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst_       (rst_),
    .push       (push),
    .push_data  (core_cipher),
    .full       (fifo_full),
    .level      (fifo_level),
    .dout       (io.dout),
    .dout_valid (io.dout_valid),
    .dout_ready (io.dout_ready),
    .dout_last  (io.dout_last)
  );

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb/tb_aes_mode_ctrl.sv - directed self-checking bench for aes_mode_ctrl
//
// Purpose: byte-wide instance (OUT_DEPTH=2) for ECB, CBC, back-pressure,
// type-change and reset cases; 32-in/128-out instance for width handling.
// The core is a stub: cipher = block ^ key, core_done 12 cycles after start.
module tb_aes_mode_ctrl;
  import aes_mode_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  aes_mode_ctrl_if #(.DIN_W(8),  .DOUT_W(8))   if0 ();
  aes_mode_ctrl_if #(.DIN_W(32), .DOUT_W(128)) if1 ();

  logic         mode0, mode1;
  logic [127:0] key0, blk0, key1, blk1;
  logic [127:0] cip0 = '0, cip1 = '0;
  logic         start0, read0, start1, read1;
  logic         done0 = 1'b0, done1 = 1'b0;
  logic [1:0]   lvl0;
  logic [0:0]   lvl1;
  logic         busy0, busy1, err0, err1;
  int           cnt0 = 0, cnt1 = 0;
  int           starts0 = 0, reads0 = 0, errs0 = 0;

  logic [7:0]   q0 [$];
  logic         ql0 [$];
  logic [127:0] q1 [$];
  logic         ql1 [$];

  logic [127:0] k1 = 128'h0f0e0d0c0b0a09080706050403020100;
  logic [127:0] p1 = 128'hffeeddccbbaa99887766554433221100;

  aes_mode_ctrl #(.DIN_W(8), .DOUT_W(8), .OUT_DEPTH(2)) u_dut0 (
    .clk(clk), .rst_(rst_), .mode(mode0), .io(if0.slave),
    .core_key(key0), .core_block(blk0), .core_start(start0), .core_done(done0),
    .core_cipher(cip0), .core_read(read0), .fifo_level(lvl0), .busy(busy0), .err(err0)
  );

  aes_mode_ctrl #(.DIN_W(32), .DOUT_W(128), .OUT_DEPTH(1)) u_dut1 (
    .clk(clk), .rst_(rst_), .mode(mode1), .io(if1.slave),
    .core_key(key1), .core_block(blk1), .core_start(start1), .core_done(done1),
    .core_cipher(cip1), .core_read(read1), .fifo_level(lvl1), .busy(busy1), .err(err1)
  );

  // Core stubs: not reset, so a done still arrives after a mid-operation reset.
  always @(posedge clk) begin
    if (start0) begin
      cip0 <= blk0 ^ key0; done0 <= 1'b0; cnt0 <= 12;
    end else if (cnt0 > 0) begin
      cnt0 <= cnt0 - 1;
      if (cnt0 == 1) done0 <= 1'b1;
    end else if (read0) begin
      done0 <= 1'b0;
    end
    if (start1) begin
      cip1 <= blk1 ^ key1; done1 <= 1'b0; cnt1 <= 12;
    end else if (cnt1 > 0) begin
      cnt1 <= cnt1 - 1;
      if (cnt1 == 1) done1 <= 1'b1;
    end else if (read1) begin
      done1 <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (if0.dout_valid && if0.dout_ready) begin
      q0.push_back(if0.dout); ql0.push_back(if0.dout_last);
    end
    if (if1.dout_valid && if1.dout_ready) begin
      q1.push_back(if1.dout); ql1.push_back(if1.dout_last);
    end
    if (start0) starts0 <= starts0 + 1;
    if (read0)  reads0  <= reads0 + 1;
    if (err0)   errs0   <= errs0 + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send0(input logic [1:0] t, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if0.din = b; if0.din_type = t; if0.din_valid = 1'b1;
    while (!if0.din_ready && n < 500) begin @(negedge clk); n++; end
    if (!if0.din_ready) check("send0_ready", if0.din_ready, 1);
    @(posedge clk);
  endtask

  task automatic send1(input logic [1:0] t, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    if1.din = w; if1.din_type = t; if1.din_valid = 1'b1;
    while (!if1.din_ready && n < 500) begin @(negedge clk); n++; end
    if (!if1.din_ready) check("send1_ready", if1.din_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle0();
    @(negedge clk); if0.din_valid = 1'b0;
  endtask

  task automatic send_block0(input logic [1:0] t, input logic [7:0] b);
    for (int i = 0; i < 16; i++) send0(t, b);
  endtask

  task automatic get_block0(output logic [127:0] blk, output logic [15:0] lm);
    int n = 0;
    blk = '0; lm = '0;
    while (q0.size() < 16 && n < 2000) begin @(negedge clk); n++; end
    if (q0.size() < 16) begin
      check("rx_timeout", q0.size(), 16);
      return;
    end
    for (int i = 0; i < 16; i++) begin
      blk = {blk[119:0], q0.pop_front()};
      lm  = {lm[14:0], ql0.pop_front()};
    end
  endtask

  task automatic run_plain0(input string tag, input logic [7:0] b,
                            input logic [127:0] exp_blk, input logic [127:0] exp_cip);
    logic [127:0] c;
    logic [15:0]  lm;
    send_block0(DT_PLAIN, b);
    #1;
    check({tag, "_blk"}, blk0, exp_blk);
    idle0();
    get_block0(c, lm);
    check({tag, "_cip"}, c, exp_cip);
    check({tag, "_last"}, lm, 16'h0001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] c;
    logic [15:0]  lm;
    int s0, r0, e0, n;

    if0.din = '0; if0.din_type = DT_KEY; if0.din_valid = 1'b0; if0.dout_ready = 1'b1;
    if1.din = '0; if1.din_type = DT_KEY; if1.din_valid = 1'b0; if1.dout_ready = 1'b1;
    mode0 = MODE_ECB; mode1 = MODE_ECB;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs0", {if0.din_ready, if0.dout_valid, if0.dout, if0.dout_last,
                        start0, read0, lvl0, busy0, err0}, '0);
    check("rst_key_blk0", key0 | blk0, '0);
    rst_ = 1'b0;
    #1;
    check("idle_ready0", {if0.din_ready, busy0}, 2'b10);

    // ECB with latency checks
    s0 = starts0; r0 = reads0;
    for (int i = 0; i < 16; i++) send0(DT_KEY, 8'(i));
    for (int i = 0; i < 16; i++) send0(DT_PLAIN, 8'(i * 17));
    #1;
    check("ecb_start_t1", start0, 1);
    check("ecb_block", blk0, 128'h00112233445566778899aabbccddeeff);
    check("ecb_key", key0, 128'h000102030405060708090a0b0c0d0e0f);
    idle0();
    @(negedge clk);
    check("ecb_start_pulse", start0, 0);
    n = 0;
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    check("ecb_d_read", {done0, read0}, 2'b10);
    @(negedge clk);
    check("ecb_d1_read", {read0, if0.dout_valid}, 2'b10);
    @(negedge clk);
    check("ecb_d2_valid", {read0, if0.dout_valid, lvl0}, {1'b0, 1'b1, 2'd1});
    get_block0(c, lm);
    check("ecb_cipher", c, 128'h00102030405060708090a0b0c0d0e0f0);
    check("ecb_last", lm, 16'h0001);
    check("ecb_starts", starts0 - s0, 1);
    check("ecb_reads", reads0 - r0, 1);

    // CBC chaining
    mode0 = MODE_CBC;
    send_block0(DT_KEY, 8'h00);
    send_block0(DT_IV, 8'h11);
    run_plain0("cbc1", 8'h00, {16{8'h11}}, {16{8'h11}});
    run_plain0("cbc2", 8'h00, {16{8'h11}}, {16{8'h11}});
    send_block0(DT_IV, 8'h11);
    run_plain0("cbc3", 8'h22, {16{8'h33}}, {16{8'h33}});
    run_plain0("cbc4", 8'h22, {16{8'h11}}, {16{8'h11}});

    // Back-pressure with a 2-block FIFO
    mode0 = MODE_ECB;
    @(negedge clk); if0.dout_ready = 1'b0;
    send_block0(DT_PLAIN, 8'h44);
    send_block0(DT_PLAIN, 8'h55);
    n = 0;
    while (lvl0 != 2'd2 && n < 100) begin @(negedge clk); n++; end
    check("bp_level2", lvl0, 2);
    if0.din = 8'h66; if0.din_type = DT_PLAIN; if0.din_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_ready_low", {if0.din_ready, lvl0}, {1'b0, 2'd2});
    check("bp_hold_dout", {if0.dout_valid, if0.dout}, {1'b1, 8'h44});
    if0.din_valid = 1'b0; if0.dout_ready = 1'b1;
    n = 0;
    while (lvl0 != 2'd1 && n < 100) begin @(negedge clk); n++; end
    check("bp_level1", {lvl0, if0.din_ready}, {2'd1, 1'b1});
    send_block0(DT_PLAIN, 8'h66);
    idle0();
    get_block0(c, lm); check("bp_cip_a", c, {16{8'h44}});
    get_block0(c, lm); check("bp_cip_b", c, {16{8'h55}});
    get_block0(c, lm); check("bp_cip_c", c, {16{8'h66}});

    // Mid-block type change and reserved type
    e0 = errs0; s0 = starts0;
    for (int i = 0; i < 5; i++) send0(DT_PLAIN, 8'h77);
    send0(DT_IV, 8'h99);
    #1;
    check("tc_err", err0, 1);
    for (int i = 0; i < 15; i++) send0(DT_IV, 8'h99);
    idle0();
    repeat (2) @(negedge clk);
    check("tc_err_count", errs0 - e0, 1);
    check("tc_no_start", {starts0 - s0, busy0}, '0);
    send0(DT_RSVD, 8'h5a);
    #1;
    check("rsvd_err", err0, 1);
    idle0();
    mode0 = MODE_CBC;
    run_plain0("tc_iv", 8'h00, {16{8'h99}}, {16{8'h99}});
    mode0 = MODE_ECB;

    // Reset while waiting on the core
    r0 = reads0;
    send_block0(DT_PLAIN, 8'haa);
    idle0();
    repeat (3) @(negedge clk);
    check("rst_busy_wait", busy0, 1);
    rst_ = 1'b1;
    #1;
    check("rst_mid_outs", {if0.din_ready, if0.dout_valid, if0.dout, if0.dout_last,
                           start0, read0, lvl0, busy0, err0}, '0);
    check("rst_mid_key_blk", key0 | blk0, '0);
    repeat (2) @(negedge clk);
    rst_ = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_late_done", {busy0, read0, lvl0, if0.dout_valid}, '0);
    check("rst_no_read", reads0 - r0, 0);
    run_plain0("rst_next", 8'hbb, {16{8'hbb}}, {16{8'hbb}});

    // 32-bit words in, one 128-bit beat out
    for (int i = 0; i < 4; i++) send1(DT_KEY, k1[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) send1(DT_PLAIN, p1[127-32*i -: 32]);
    #1;
    check("w32_blk", blk1, p1);
    @(negedge clk); if1.din_valid = 1'b0;
    n = 0;
    while (q1.size() < 1 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("w32_beats", q1.size(), 1);
    if (q1.size() > 0) begin
      check("w32_cip", q1[0], 128'hf0e0d0c0b0a090807060504030201000);
      check("w32_last", ql1[0], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
